// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the elevator car controller,
// stop memory and panel logic.
package elevator_pkg;

  localparam int NFLOORS = 4;

  typedef logic [1:0]         floor_t;
  typedef logic [NFLOORS-1:0] fmask_t;

  typedef enum logic [1:0] {IDLE, MOVE, ARRIVE, DOOR} state_t;

  function automatic fmask_t floor_bit(floor_t f);
    return fmask_t'(1) << f;
  endfunction

  function automatic fmask_t below_mask(floor_t f);
    return floor_bit(f) - fmask_t'(1);
  endfunction

  function automatic fmask_t above_mask(floor_t f);
    return ~(below_mask(f) | floor_bit(f));
  endfunction

  // Terminal floors have only one meaningful direction.
  function automatic logic is_end(floor_t f);
    return (f == floor_t'(0)) || (f == floor_t'(NFLOORS - 1));
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door dwell; hold freezes it.
module elevator_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/elevator_motion_controller.sv
// Collective (SCAN) sequencing of a 4-floor car: motor, door and stop-clear
// strobes back to the stop memory. All outputs are registered.
module elevator_motion_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 100,
  parameter int DOOR_CYCLES   = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] stop_up,
  input  logic [3:0] stop_dn,
  input  logic       door_hold,
  input  logic       estop,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       moving,
  output logic       door_open,
  output logic [3:0] clr_up,
  output logic [3:0] clr_dn,
  output logic       idle
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(MAX_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  state_t  state_reg, state_next;
  floor_t  floor_next;
  logic    dir_next;
  logic    both_reg, both_next;
  fmask_t  pend;
  logic    here, above, below, ahead, same_hit, opp_hit;
  logic    tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic    both_eff;
  fmask_t  clr_up_next, clr_dn_next;

  assign pend     = stop_up | stop_dn;
  assign here     = pend[cur_floor];
  assign above    = |(pend & above_mask(cur_floor));
  assign below    = |(pend & below_mask(cur_floor));
  assign ahead    = dir_up ? above : below;
  assign same_hit = is_end(cur_floor) ? here : (dir_up ? stop_up[cur_floor] : stop_dn[cur_floor]);
  assign opp_hit  = dir_up ? stop_dn[cur_floor] : stop_up[cur_floor];

  always_comb begin
    state_next = state_reg;
    floor_next = cur_floor;
    dir_next   = dir_up;
    both_next  = both_reg;
    tmr_load   = 1'b0;
    tmr_val    = TRAVEL_LOAD;
    if (!estop) begin
      case (state_reg)
        IDLE: begin
          if (here) begin
            state_next = DOOR;
            both_next  = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = DOOR_LOAD;
          end else if ((dir_up & above) | (!dir_up & !below & above)) begin
            dir_next   = 1'b1;
            state_next = MOVE;
            tmr_load   = 1'b1;
          end else if (below) begin
            dir_next   = 1'b0;
            state_next = MOVE;
            tmr_load   = 1'b1;
          end
        end
        MOVE: begin
          if (tmr_zero) begin
            floor_next = dir_up ? cur_floor + 2'd1 : cur_floor - 2'd1;
            state_next = ARRIVE;
          end
        end
        ARRIVE: begin
          if (same_hit || (opp_hit && !ahead)) begin
            // A lone opposite-direction call at the end of the sweep turns the car here.
            dir_next   = same_hit ? dir_up : !dir_up;
            both_next  = 1'b0;
            state_next = DOOR;
            tmr_load   = 1'b1;
            tmr_val    = DOOR_LOAD;
          end else if (ahead) begin
            state_next = MOVE;
            tmr_load   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
        DOOR: begin
          if (door_hold) begin
            tmr_load = 1'b1;
            tmr_val  = DOOR_LOAD;
          end else if (tmr_zero) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Doors opened from IDLE, or at a terminal floor, serve both call buttons.
  always_comb begin
    clr_up_next = '0;
    clr_dn_next = '0;
    both_eff    = both_next | is_end(floor_next);
    if (state_next == DOOR && !estop) begin
      if (both_eff) begin
        clr_up_next = floor_bit(floor_next) & {NFLOORS{pend[floor_next]}};
        clr_dn_next = floor_bit(floor_next) & {NFLOORS{pend[floor_next]}};
      end else if (dir_next) begin
        clr_up_next = floor_bit(floor_next) & stop_up;
      end else begin
        clr_dn_next = floor_bit(floor_next) & stop_dn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      both_reg  <= 1'b0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      idle      <= 1'b1;
      clr_up    <= '0;
      clr_dn    <= '0;
    end else begin
      state_reg <= state_next;
      cur_floor <= floor_next;
      dir_up    <= dir_next;
      both_reg  <= both_next;
      moving    <= (state_next == MOVE) && !estop;
      door_open <= (state_next == DOOR);
      idle      <= (state_next == IDLE);
      clr_up    <= clr_up_next;
      clr_dn    <= clr_dn_next;
    end
  end

  elevator_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .hold     (estop),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

endmodule

// File: doc/elevator_motion_controller.md
# elevator_motion_controller

Sequencing controller for the 4-floor car. It reads the pending-stop bitmaps held by the stop memory and decides travel direction with collective (SCAN) scheduling. It drives the motor-enable/direction and door outputs, timing floor-to-floor travel and door dwell with an internal countdown. It issues clear strobes back to the stop memory for every stop it serves, so the memory block holds requests and this block consumes them.

## Interface
- NFLOORS, 4: number of floors; fixed at 4 for this design, and floor index is 2 bits.
- TRAVEL_CYCLES, 100: cycles spent in MOVE per floor; must be ≥2.
- DOOR_CYCLES, 50: door dwell cycles; must be ≥2.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stop_up  in  4  pending up-direction stops, one bit per floor; level, held by stop memory until cleared.
- stop_dn  in  4  pending down-direction stops, per floor; level.
- door_hold  in  1  door-reopen button / obstruction; level.
- estop  in  1  emergency stop; level.
- cur_floor  out  2  current floor; reset 0.
- dir_up  out  1  scan direction, 1 = up; reset 1.
- moving  out  1  motor enable; high only in MOVE with estop low; reset 0.
- door_open  out  1  high only in DOOR; reset 0.
- clr_up  out  4  clear strobe for stop_up bits; reset 0.
- clr_dn  out  4  clear strobe for stop_dn bits; reset 0.
- idle  out  1  high in IDLE; reset 1.

## Operation
- Derived signals:
  - pend = stop_up|stop_dn.
  - here = pend[cur_floor].
  - above = |pend bits above cur_floor.
  - below = |pend bits below cur_floor.
  - At floor 0 and floor 3, stop_up and stop_dn bits are equivalent; both are served and cleared together.
- States: IDLE, MOVE, ARRIVE, DOOR.
- IDLE:
  - If here: go to DOOR and clear both bits at cur_floor.
  - Else if (dir_up & above) | (!dir_up & !below & above): set dir_up=1, go to MOVE.
  - Else if below: set dir_up=0, go to MOVE.
  - Otherwise stay in IDLE.
  - Continuing the current direction always has priority over reversing.
- MOVE:
  - Countdown loads TRAVEL_CYCLES-1 on entry.
  - At 0, cur_floor steps ±1 per dir_up and the state goes to ARRIVE.
  - cur_floor never wraps. A move is only started with a pending stop beyond cur_floor, so the floor saturates at 0 and 3 by construction.
- ARRIVE (1 cycle, moving=0):
  - Same-direction stop at cur_floor (stop_up when dir_up, stop_dn when down): go to DOOR.
  - Opposite-direction stop at cur_floor with nothing further ahead in dir_up: flip dir_up, then go to DOOR.
  - Else if stops remain ahead: go to MOVE.
  - Else: go to IDLE.
- DOOR:
  - door_open=1; countdown loads DOOR_CYCLES-1 on entry.
  - door_hold high reloads the countdown every cycle.
  - At 0 with door_hold low, go to IDLE.
- Clear rule:
  - In DOOR, clr_up[cur_floor] or clr_dn[cur_floor] (served direction per dir_up) is asserted every cycle the matching stop bit is set.
  - A request for the current floor and direction that arrives while the door is open is absorbed without extending dwell.
  - No other clr bits are ever asserted.
- estop:
  - While high, the countdown and state freeze; moving is forced 0; door_open holds its value; clr outputs are forced 0.
  - On release, operation resumes from the frozen count.
- Reset mid-operation: all state returns to reset values immediately (floor 0, IDLE). Stop memory contents are not touched.

## Timing
- All outputs are registered; none is combinational from inputs.
- Request at IDLE sampled at edge N: state=MOVE and moving=1 from edge N+1.
- Per-floor travel: exactly TRAVEL_CYCLES cycles with moving=1. cur_floor updates on the same edge that enters ARRIVE.
- ARRIVE: moving=0 for 1 cycle. Passing a floor without stopping costs 1 cycle of moving=0.
- DOOR: door_open high for exactly DOOR_CYCLES cycles when door_hold is never asserted. The first clr strobe coincides with the first door_open cycle.
- Simultaneous here and above/below in IDLE: the door opens first; the move is decided after the dwell.

## Structure
- Package elevator_pkg:
  - state enum {IDLE, MOVE, ARRIVE, DOOR}.
  - NFLOORS constant.
  - floor_t (2-bit) typedef.
  - Shared by the stop memory and the panel logic.
- Sub-module elevator_timer: loadable countdown with load, hold (estop) and zero flag. One instance is reused for travel and dwell, width $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)).

## Test plan
All scenarios use TRAVEL_CYCLES=4 and DOOR_CYCLES=3.
- Reset, then stop_up[0]=1 at floor 0 → next cycle door_open=1 and clr_up[0]=clr_dn[0]=1; door_open lasts 3 cycles, then idle=1.
- At floor 0, stop_dn[3]=1 → moving=1 for 3×4 cycles with 2 single-cycle ARRIVE gaps; cur_floor sequence 1,2,3; door opens at floor 3; clr_dn[3] pulses.
- Moving up from floor 0 with stop_dn[1] and stop_up[2] set → passes floor 1, serves 2 (clr_up[2]), reverses, serves 1 (clr_dn[1]); dir_up=0 at floor 1.
- door_hold held 5 cycles during DOOR → door_open stays high for 5 + 3 cycles after release begins countdown.
- estop asserted for 10 cycles mid-MOVE at count 2 → moving=0 and cur_floor unchanged; after release, arrival occurs after the remaining 2 cycles.
- rst_n low for 1 cycle during MOVE at floor 2 → cur_floor=0, idle=1, moving=0 asynchronously; pending stops are rescheduled afterwards.
